solve_sequencer: RTL and testbench
==================================

SOLVE_SEQUENCER -- requirements
Module: solve_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_start, input, 1, one-cycle pulse that starts a solve run; ignored unless idle.
REQ-004 SHALL have port i_klotski, input, [3:0][3:0][3:0], initial board (row, column, tile value; 0 = blank), sampled with i_start.
REQ-005 SHALL have port o_mv_start, output, 1, one-cycle start pulse to the tile mover.
REQ-006 SHALL have ports o_mv_klotski [3:0][3:0][3:0], o_mv_mask [3:0][3:0], o_mv_target [1:0][1:0] {row,col}, o_mv_number [3:0] and o_mv_flag 1, all outputs holding the command for the tile mover.
REQ-007 SHALL have ports i_mv_klotski [3:0][3:0][3:0], i_mv_mask [3:0][3:0] and i_mv_finished 1, all inputs carrying the mover result and its one-cycle completion pulse.
REQ-008 SHALL have ports o_klotski [3:0][3:0][3:0] (current board), o_step [3:0] (current step index), o_busy 1, o_done 1 (one-cycle pulse), o_solved 1 and o_error 1, all outputs.

Function
REQ-009 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_CHECK and S_DONE.
REQ-010 S_IDLE with i_start SHALL latch i_klotski into the board register, clear the mask register, clear step to 0, clear o_solved and o_error, and go to S_ISSUE.
REQ-011 S_ISSUE SHALL drive the command for table entry step and assert o_mv_start for exactly one cycle.
- o_mv_number = entry tile; o_mv_target = entry position.
- o_mv_flag = ~entry.lock; flag 0 locks the tile in the mask after placement.
- o_mv_klotski and o_mv_mask = the registered board and mask.
- Next state: S_WAIT.
REQ-012 Command outputs SHALL stay stable from the o_mv_start cycle until i_mv_finished is sampled.
REQ-013 S_WAIT with i_mv_finished SHALL capture i_mv_klotski and i_mv_mask into the board and mask registers.
- If step == NUM_STEPS-1: go to S_CHECK.
- Otherwise: increment step and go to S_ISSUE. Gap from the finished pulse to the next o_mv_start is 1 cycle.
REQ-014 A 20-bit watchdog SHALL clear on entering S_WAIT and increment each cycle in S_WAIT.
- On reaching TIMEOUT without i_mv_finished: set o_error and go to S_DONE.
- If i_mv_finished and the timeout occur in the same cycle, i_mv_finished wins.
REQ-015 S_CHECK SHALL set o_solved = 1 iff every cell (r,c) equals 4r+c+1, except cell (3,3), which must equal 0; then go to S_DONE.
REQ-016 S_DONE SHALL pulse o_done for one cycle and return to S_IDLE; o_solved and o_error hold until the next accepted i_start.
REQ-017 o_busy SHALL be 1 in every state except S_IDLE.
REQ-018 i_start SHALL be ignored outside S_IDLE.
REQ-019 An i_mv_finished pulse outside S_WAIT SHALL be ignored and SHALL NOT alter the board.
REQ-020 o_klotski SHALL always equal the board register; o_step SHALL always equal the step register.

Reset
REQ-021 Reset SHALL force the following, regardless of the operation in progress:
- state to S_IDLE;
- board, mask, step and watchdog to 0;
- o_mv_start, o_done, o_solved, o_error and o_busy to 0.
REQ-022 Reset SHALL drive all command outputs to 0.

Structure
REQ-023 The shared package SHALL hold the state typedef, step_t {tile[3:0], row[1:0], col[1:0], lock}, NUM_STEPS = 11, TIMEOUT = 20'hFFFFF and STEP_TABLE.
- Entry k places tile k+1 at (k/4, k%4).
- lock = 1 for k < 10; lock = 0 for k = 10.
REQ-024 The block SHALL NOT instantiate the tile mover; it connects to the mover's ports at the level above. No sub-module is required.

Verification
REQ-025 Solved-input run: i_start with an already-solved board and a mover model that echoes the board after 5 cycles SHALL produce:
- 11 o_mv_start pulses with targets (0,0), (0,1) … (2,2);
- o_done exactly once, o_solved = 1, o_error = 0.
REQ-026 Mover model returning a board with tiles 1 and 2 swapped on step 10 SHALL end with o_solved = 0 and o_done = 1.
REQ-027 Mover that never finishes on step 3 SHALL give o_error = 1 and o_done after TIMEOUT cycles, with o_step = 3.
REQ-028 i_start pulsed during S_WAIT and a stray i_mv_finished in S_IDLE SHALL both leave the state and board unchanged.
REQ-029 Asserting i_rst_n low during step 5 SHALL return all outputs to 0 immediately; a fresh i_start SHALL then begin at step 0.
REQ-030 Mask propagation: the mask returned on step k SHALL appear on o_mv_mask at step k+1, and o_mv_flag SHALL be 0 for steps 0–9 and 1 for step 10.

Source files
------------

// File: rtl/solve_sequencer_pkg.sv
// Shared types, constants and the fixed placement table for the klotski solve sequencer.
// Also holds the solved-board predicate used at the end of a run.
package solve_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] tile;
    logic [1:0] row;
    logic [1:0] col;
    logic       lock;
  } step_t;

  typedef logic [3:0][3:0][3:0] board_t;
  typedef logic [3:0][3:0]      mask_t;

  localparam int          NUM_STEPS = 11;
  localparam logic [19:0] TIMEOUT   = 20'hFFFFF;

  // Entry k places tile k+1 at (k/4, k%4); the last placement is left unlocked.
  localparam step_t [0:NUM_STEPS-1] STEP_TABLE = '{
    '{tile: 4'd1,  row: 2'd0, col: 2'd0, lock: 1'b1},
    '{tile: 4'd2,  row: 2'd0, col: 2'd1, lock: 1'b1},
    '{tile: 4'd3,  row: 2'd0, col: 2'd2, lock: 1'b1},
    '{tile: 4'd4,  row: 2'd0, col: 2'd3, lock: 1'b1},
    '{tile: 4'd5,  row: 2'd1, col: 2'd0, lock: 1'b1},
    '{tile: 4'd6,  row: 2'd1, col: 2'd1, lock: 1'b1},
    '{tile: 4'd7,  row: 2'd1, col: 2'd2, lock: 1'b1},
    '{tile: 4'd8,  row: 2'd1, col: 2'd3, lock: 1'b1},
    '{tile: 4'd9,  row: 2'd2, col: 2'd0, lock: 1'b1},
    '{tile: 4'd10, row: 2'd2, col: 2'd1, lock: 1'b1},
    '{tile: 4'd11, row: 2'd2, col: 2'd2, lock: 1'b0}
  };

  function automatic logic board_solved(input board_t b);
    logic       ok;
    logic [3:0] want;
    ok = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ((r == 3) && (c == 3)) begin
          want = 4'd0;
        end else begin
          want = 4'(4 * r + c + 1);
        end
        if (b[r][c] != want) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/solve_sequencer_if.sv
// Command/result channel between the solve sequencer (master) and the tile mover (slave).
interface solve_sequencer_if;
  import solve_sequencer_pkg::*;

  logic            o_mv_start;
  board_t          o_mv_klotski;
  mask_t           o_mv_mask;
  logic [1:0][1:0] o_mv_target;
  logic [3:0]      o_mv_number;
  logic            o_mv_flag;
  board_t          i_mv_klotski;
  mask_t           i_mv_mask;
  logic            i_mv_finished;

  modport master (
    output o_mv_start, o_mv_klotski, o_mv_mask, o_mv_target, o_mv_number, o_mv_flag,
    input  i_mv_klotski, i_mv_mask, i_mv_finished
  );

  modport slave (
    input  o_mv_start, o_mv_klotski, o_mv_mask, o_mv_target, o_mv_number, o_mv_flag,
    output i_mv_klotski, i_mv_mask, i_mv_finished
  );

endinterface

// File: rtl/solve_sequencer.sv
// Walks the placement table, issuing one mover command per step, then checks the final board.
// A watchdog aborts the run with o_error if the mover stalls.
module solve_sequencer
  import solve_sequencer_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_P = TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  board_t                i_klotski,
  solve_sequencer_if.master     mv,
  output board_t                o_klotski,
  output logic [3:0]            o_step,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_solved,
  output logic                  o_error
);

  state_t          state_q;
  board_t          board_q;
  mask_t           mask_q;
  logic [3:0]      step_q;
  logic [19:0]     wdog_q;
  logic            mv_start_q;
  logic [1:0][1:0] target_q;
  logic [3:0]      number_q;
  logic            flag_q;
  logic            busy_q;
  logic            done_q;
  logic            solved_q;
  logic            error_q;

  logic [3:0]      step_next_d;
  step_t           entry_next_d;

  // Table lookup for the step that follows the current one.
  always_comb begin
    step_next_d = step_q + 4'd1;
    if (step_next_d < 4'(NUM_STEPS)) begin
      entry_next_d = STEP_TABLE[step_next_d];
    end else begin
      entry_next_d = STEP_TABLE[0];
    end
  end

  // Sequencer FSM; command registers load on entry to S_ISSUE so they are stable through S_WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      mask_q     <= '0;
      step_q     <= 4'd0;
      wdog_q     <= 20'd0;
      mv_start_q <= 1'b0;
      target_q   <= '0;
      number_q   <= 4'd0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      solved_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            board_q    <= i_klotski;
            mask_q     <= '0;
            step_q     <= 4'd0;
            solved_q   <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            mv_start_q <= 1'b1;
            target_q   <= {STEP_TABLE[0].row, STEP_TABLE[0].col};
            number_q   <= STEP_TABLE[0].tile;
            flag_q     <= ~STEP_TABLE[0].lock;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mv_start_q <= 1'b0;
          wdog_q     <= 20'd0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A finish in the same cycle as the timeout still counts as a finish.
          if (mv.i_mv_finished) begin
            board_q <= mv.i_mv_klotski;
            mask_q  <= mv.i_mv_mask;
            if (step_q == 4'(NUM_STEPS - 1)) begin
              state_q <= S_CHECK;
            end else begin
              step_q     <= step_next_d;
              mv_start_q <= 1'b1;
              target_q   <= {entry_next_d.row, entry_next_d.col};
              number_q   <= entry_next_d.tile;
              flag_q     <= ~entry_next_d.lock;
              state_q    <= S_ISSUE;
            end
          end else if (wdog_q == TIMEOUT_P) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + 20'd1;
          end
        end
        S_CHECK: begin
          solved_q <= board_solved(board_q);
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mv_start_q <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign mv.o_mv_start   = mv_start_q;
  assign mv.o_mv_klotski = board_q;
  assign mv.o_mv_mask    = mask_q;
  assign mv.o_mv_target  = target_q;
  assign mv.o_mv_number  = number_q;
  assign mv.o_mv_flag    = flag_q;

  assign o_klotski = board_q;
  assign o_step    = step_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_solved  = solved_q;
  assign o_error   = error_q;

endmodule

// File: tb/tb_solve_sequencer.sv
// Self-checking bench: scenario table, hand-written reset/stray-pulse sequences and randomized
// runs, all against a step-level mover/board model kept in the bench.
module tb_solve_sequencer;
  import solve_sequencer_pkg::*;

  localparam logic [19:0] TMO = 20'd300;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  board_t kin   = '0;
  board_t o_kl;
  logic [3:0] o_step;
  logic   busy, done, solved, err;

  solve_sequencer_if mvif();

  solve_sequencer #(.TIMEOUT_P(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_klotski(kin), .mv(mvif),
    .o_klotski(o_kl), .o_step(o_step), .o_busy(busy), .o_done(done),
    .o_solved(solved), .o_error(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic board_t goal_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = (r == 3 && c == 3) ? 4'd0 : 4'(r * 4 + c + 1);
    return b;
  endfunction

  function automatic board_t reversed_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = 4'(15 - (r * 4 + c));
    return b;
  endfunction

  function automatic bit ref_solved(input board_t b);
    return (b == goal_board());
  endfunction

  // run bookkeeping / model state
  int     r_starts, r_done_cnt, r_done_cyc, r_fin_cyc;
  int     r_start_cyc[16];
  bit     r_aborted;
  board_t mdl_board;
  mask_t  mdl_mask;

  task automatic run(input board_t init, input int delay, input int hang_step, input int swap_step,
                     input int inject_step, input int rst_step, input bit rand_mode);
    int cnt, cur;
    bit pending;
    board_t cap_kl, ret;
    mask_t cap_mask, rmask;
    logic [24:0] cap_small;
    r_starts = 0; r_done_cnt = 0; r_done_cyc = -1; r_fin_cyc = -1; r_aborted = 0;
    pending = 0; cnt = 0; cur = 0; cap_kl = '0; cap_mask = '0; cap_small = '0;
    mdl_board = init; mdl_mask = '0;
    @(negedge clk);
    start = 1'b1; kin = init;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      mvif.i_mv_finished = 1'b0;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = cyc;
          chk("busy_in_done", {63'd0, busy}, 64'd1);
        end
      end
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 3) break;
      if (mvif.o_mv_start) begin
        cur = r_starts;
        r_start_cyc[cur & 15] = cyc;
        r_starts++;
        if (cur > 0) chk("finish_to_start_gap", 64'(cyc - r_fin_cyc), 64'd1);
        chk("step_idx", {60'd0, o_step}, 64'(cur));
        chk("target_row", {62'd0, mvif.o_mv_target[1]}, 64'(cur / 4));
        chk("target_col", {62'd0, mvif.o_mv_target[0]}, 64'(cur % 4));
        chk("tile_number", {60'd0, mvif.o_mv_number}, 64'(cur + 1));
        chk("mv_flag", {63'd0, mvif.o_mv_flag}, {63'd0, (cur == 10)});
        chk("mv_klotski", mvif.o_mv_klotski, mdl_board);
        chk("mv_mask", {48'd0, mvif.o_mv_mask}, {48'd0, mdl_mask});
        chk("o_klotski", o_kl, mdl_board);
        chk("busy_run", {63'd0, busy}, 64'd1);
        cap_kl = mvif.o_mv_klotski;
        cap_mask = mvif.o_mv_mask;
        cap_small = {mvif.o_mv_mask, mvif.o_mv_number, mvif.o_mv_target, mvif.o_mv_flag};
        pending = 1'b1;
        cnt = delay;
      end else if (pending) begin
        chk("cmd_stable_board", mvif.o_mv_klotski, cap_kl);
        chk("cmd_stable_fields",
            {39'd0, mvif.o_mv_mask, mvif.o_mv_number, mvif.o_mv_target, mvif.o_mv_flag},
            {39'd0, cap_small});
        if (cur == inject_step && cnt == delay) begin
          start = 1'b1;
          kin = ~init;
        end
        if (cur == rst_step && cnt == 2) begin
          rst_n = 1'b0;
          #1;
          chk("rst_board", o_kl, 64'd0);
          chk("rst_status", {58'd0, o_step, busy, done, solved, err}, 64'd0);
          chk("rst_cmd", {36'd0, mvif.o_mv_start, mvif.o_mv_mask, mvif.o_mv_number,
                          mvif.o_mv_target, mvif.o_mv_flag}, 64'd0);
          chk("rst_mv_board", mvif.o_mv_klotski, 64'd0);
          @(negedge clk);
          rst_n = 1'b1;
          start = 1'b0;
          r_aborted = 1'b1;
          break;
        end
        cnt--;
        if (cnt == 0 && cur != hang_step) begin
          pending = 1'b0;
          if (rand_mode) begin
            ret = {$urandom, $urandom};
            if (cur == 10 && $urandom_range(0, 1) == 1) ret = goal_board();
            rmask = mask_t'($urandom);
          end else begin
            ret = cap_kl;
            rmask = cap_mask;
            if (cap_small[0] == 1'b0) rmask[cap_small[4:3]][cap_small[2:1]] = 1'b1;
          end
          if (cur == swap_step) begin
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                if (ret[r][c] == 4'd1) ret[r][c] = 4'd2;
                else if (ret[r][c] == 4'd2) ret[r][c] = 4'd1;
          end
          mvif.i_mv_klotski = ret;
          mvif.i_mv_mask = rmask;
          mvif.i_mv_finished = 1'b1;
          mdl_board = ret;
          mdl_mask = rmask;
          r_fin_cyc = cyc;
        end
      end
    end
    if (!r_aborted && r_done_cyc < 0) chk("done_within_bound", 64'd0, 64'd1);
  endtask

  typedef struct {
    int kind;       // 0 = goal board, 1 = reversed board
    int delay;
    int hang;
    int swap;
    int inject;
    bit exp_solved;
    bit exp_error;
    int exp_starts;
    int exp_step;
  } vec_t;

  vec_t   tbl[6];
  board_t hold, init_b;
  bit     last_solved;

  initial begin
    tbl[0] = '{kind: 0, delay: 5, hang: -1, swap: -1, inject: -1, exp_solved: 1, exp_error: 0, exp_starts: 11, exp_step: 10};
    tbl[1] = '{kind: 0, delay: 5, hang: -1, swap: 10, inject: -1, exp_solved: 0, exp_error: 0, exp_starts: 11, exp_step: 10};
    tbl[2] = '{kind: 0, delay: 5, hang: 3,  swap: -1, inject: -1, exp_solved: 0, exp_error: 1, exp_starts: 4,  exp_step: 3};
    tbl[3] = '{kind: 0, delay: 4, hang: -1, swap: -1, inject: 2,  exp_solved: 1, exp_error: 0, exp_starts: 11, exp_step: 10};
    tbl[4] = '{kind: 0, delay: 1, hang: -1, swap: -1, inject: -1, exp_solved: 1, exp_error: 0, exp_starts: 11, exp_step: 10};
    tbl[5] = '{kind: 1, delay: 2, hang: -1, swap: -1, inject: -1, exp_solved: 0, exp_error: 0, exp_starts: 11, exp_step: 10};

    mvif.i_mv_klotski = '0;
    mvif.i_mv_mask = '0;
    mvif.i_mv_finished = 1'b0;
    last_solved = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_board", o_kl, 64'd0);
    chk("reset_status", {58'd0, o_step, busy, done, solved, err}, 64'd0);
    chk("reset_cmd", {36'd0, mvif.o_mv_start, mvif.o_mv_mask, mvif.o_mv_number,
                      mvif.o_mv_target, mvif.o_mv_flag}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      init_b = (tbl[i].kind == 0) ? goal_board() : reversed_board();
      run(init_b, tbl[i].delay, tbl[i].hang, tbl[i].swap, tbl[i].inject, -1, 1'b0);
      chk("tbl_done_once", 64'(r_done_cnt), 64'd1);
      chk("tbl_starts", 64'(r_starts), 64'(tbl[i].exp_starts));
      chk("tbl_solved", {63'd0, solved}, {63'd0, tbl[i].exp_solved});
      chk("tbl_error", {63'd0, err}, {63'd0, tbl[i].exp_error});
      chk("tbl_step", {60'd0, o_step}, 64'(tbl[i].exp_step));
      chk("tbl_board", o_kl, mdl_board);
      chk("tbl_idle", {62'd0, busy, done}, 64'd0);
      if (tbl[i].hang >= 0)
        chk("timeout_latency", 64'(r_done_cyc - r_start_cyc[tbl[i].hang]), 64'(TMO) + 64'd2);
      last_solved = tbl[i].exp_solved;
    end

    // stray finish pulse while idle must not touch the board or status
    @(negedge clk);
    hold = o_kl;
    mvif.i_mv_klotski = ~hold;
    mvif.i_mv_mask = '1;
    mvif.i_mv_finished = 1'b1;
    @(negedge clk);
    mvif.i_mv_finished = 1'b0;
    @(negedge clk);
    chk("stray_board", o_kl, hold);
    chk("stray_status", {61'd0, busy, mvif.o_mv_start, solved}, {63'd0, last_solved});

    // reset during step 5, then a fresh run from step 0
    run(goal_board(), 5, -1, -1, -1, 5, 1'b0);
    chk("rst_aborted", {63'd0, r_aborted}, 64'd1);
    chk("rst_starts", 64'(r_starts), 64'd6);
    repeat (10) @(negedge clk);
    run(goal_board(), 3, -1, -1, -1, -1, 1'b0);
    chk("post_rst_starts", 64'(r_starts), 64'd11);
    chk("post_rst_solved", {62'd0, solved, err}, 64'd2);

    for (int n = 0; n < 8; n++) begin
      init_b = {$urandom, $urandom};
      run(init_b, $urandom_range(1, 6), -1, -1, -1, -1, 1'b1);
      chk("rnd_done_once", 64'(r_done_cnt), 64'd1);
      chk("rnd_starts", 64'(r_starts), 64'd11);
      chk("rnd_solved", {63'd0, solved}, {63'd0, ref_solved(mdl_board)});
      chk("rnd_error", {63'd0, err}, 64'd0);
      chk("rnd_board", o_kl, mdl_board);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
